// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the multiply/divide HI/LO sequencer.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Bit 1 of the op code selects divide, bit 0 selects signed.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Multiply: acc = {partial product high, product low bits shifting in}.
// Divide:   acc = {remainder, quotient bits shifting in at the LSB}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  input  logic                 bit_in,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_next;
  logic             ge;

  // Select between add-then-shift-right and shift-left-then-trial-subtract.
  always_comb begin
    sum      = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (bit_in ? {1'b0, mag_a} : '0);
    shifted  = {acc_in[2*WIDTH-1:WIDTH], bit_in};
    ge       = (shifted >= {1'b0, mag_b});
    // When ge holds the difference is below the divisor, so WIDTH bits suffice.
    diff     = shifted[WIDTH-1:0] - mag_b;
    rem_next = ge ? diff : shifted[WIDTH-1:0];
    acc_out  = '0;
    if (is_div) begin
      acc_out = {rem_next, acc_in[WIDTH-2:0], ge};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO, with pipeline hazard outputs.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             ReadHiD,
  input  logic             ReadLoD,
  input  logic             WriteLoHiD,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             Busy,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             state;
  logic [CW-1:0]      count;
  logic               div_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   raw_a;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  logic               neg_a_in;
  logic               neg_b_in;
  logic [WIDTH-1:0]   abs_a_in;
  logic [WIDTH-1:0]   abs_b_in;
  logic               step_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               hazard;

  // Operand magnitudes at start, iteration bit select, and final sign fix-up.
  always_comb begin
    neg_a_in = op_is_signed(OpE) & SrcAE[WIDTH-1];
    neg_b_in = op_is_signed(OpE) & SrcBE[WIDTH-1];
    abs_a_in = neg_a_in ? -SrcAE : SrcAE;
    abs_b_in = neg_b_in ? -SrcBE : SrcBE;
    // Multiply consumes multiplier bits LSB first; divide consumes dividend MSB first.
    step_bit = div_q ? mag_a[CW'(WIDTH-1) - count] : mag_b[count];
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (div_q),
    .acc_in  (acc),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .bit_in  (step_bit),
    .acc_out (acc_next)
  );

  // Sequencer FSM: capture operands, iterate WIDTH times, then commit HI/LO atomically.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      count     <= '0;
      div_q     <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      raw_a     <= '0;
      acc       <= '0;
      HiOut     <= '0;
      LoOut     <= '0;
      Busy      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      DivByZero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (StartE) begin
            div_q  <= op_is_div(OpE);
            sign_a <= neg_a_in;
            sign_b <= neg_b_in;
            mag_a  <= abs_a_in;
            mag_b  <= abs_b_in;
            raw_a  <= SrcAE;
            acc    <= '0;
            count  <= '0;
            Busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH-1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          if (div_q) begin
            if (mag_b == '0) begin
              LoOut     <= '1;
              HiOut     <= raw_a;
              DivByZero <= 1'b1;
            end else begin
              LoOut <= quot_fix;
              HiOut <= rem_fix;
            end
          end else begin
            HiOut <= prod_fix[2*WIDTH-1:WIDTH];
            LoOut <= prod_fix[WIDTH-1:0];
          end
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Hold Fetch/Decode and bubble Execute while a HI/LO consumer waits in Decode.
  assign hazard = Busy & (ReadHiD | ReadLoD | WriteLoHiD);
  assign StallF = hazard;
  assign StallD = hazard;
  assign FlushE = hazard;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;

  logic        CLK;
  logic        RST;
  logic        StartE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        ReadHiD;
  logic        ReadLoD;
  logic        WriteLoHiD;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        Busy;
  logic        StallF;
  logic        StallD;
  logic        FlushE;
  logic        DivByZero;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_hilo_ctrl #(.WIDTH(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .StartE     (StartE),
    .OpE        (OpE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .ReadHiD    (ReadHiD),
    .ReadLoD    (ReadLoD),
    .WriteLoHiD (WriteLoHiD),
    .HiOut      (HiOut),
    .LoOut      (LoOut),
    .Busy       (Busy),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushE     (FlushE),
    .DivByZero  (DivByZero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS mult/div semantics computed with 64-bit arithmetic.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint unsigned ua, ub, up;
    longint sa, sb, sp, sq, sr;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        up = ua * ub;
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b01: begin
        sp = sa * sb;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
          dz = 1'b1;
        end else if (op == 2'b10) begin
          up = ua / ub;
          lo = up[31:0];
          up = ua % ub;
          hi = up[31:0];
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          lo = sq[31:0];
          hi = sr[31:0];
        end
      end
    endcase
  endtask

  // Issue one op at a negedge; returns at the negedge of the first IDLE cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m_hi, m_lo;
    logic        m_dz;
    logic        any;
    int          cycles;
    int          dz_busy;
    model(op, a, b, m_hi, m_lo, m_dz);
    StartE = 1'b1;
    OpE    = op;
    SrcAE  = a;
    SrcBE  = b;
    @(negedge CLK);
    cycles  = 0;
    dz_busy = 0;
    while (Busy === 1'b1 && cycles < 100) begin
      if (DivByZero !== 1'b0) dz_busy++;
      check("hold_hi", {32'h0, HiOut}, {32'h0, exp_hi});
      check("hold_lo", {32'h0, LoOut}, {32'h0, exp_lo});
      // Late operand changes and a StartE while busy must be ignored.
      StartE     = 1'($urandom_range(0, 1));
      OpE        = 2'($urandom);
      SrcAE      = $urandom;
      SrcBE      = $urandom;
      ReadHiD    = 1'($urandom_range(0, 1));
      ReadLoD    = 1'($urandom_range(0, 1));
      WriteLoHiD = 1'($urandom_range(0, 1));
      any        = ReadHiD | ReadLoD | WriteLoHiD;
      #1;
      check("stall_busy", {61'h0, StallF, StallD, FlushE}, {61'h0, {3{any}}});
      cycles++;
      @(negedge CLK);
    end
    StartE = 1'b0;
    check("busy_cycles", 64'(cycles), 64'd33);
    check("dz_in_busy", 64'(dz_busy), 64'd0);
    check("dz_pulse", {63'h0, DivByZero}, {63'h0, m_dz});
    check("hi", {32'h0, HiOut}, {32'h0, m_hi});
    check("lo", {32'h0, LoOut}, {32'h0, m_lo});
    exp_hi = m_hi;
    exp_lo = m_lo;
    ReadHiD    = 1'b1;
    ReadLoD    = 1'b1;
    WriteLoHiD = 1'b1;
    #1;
    check("stall_idle", {61'h0, StallF, StallD, FlushE}, 64'd0);
    ReadHiD    = 1'b0;
    ReadLoD    = 1'b0;
    WriteLoHiD = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST        = 1'b0;
    StartE     = 1'b0;
    OpE        = 2'b00;
    SrcAE      = '0;
    SrcBE      = '0;
    ReadHiD    = 1'b0;
    ReadLoD    = 1'b0;
    WriteLoHiD = 1'b0;
    exp_hi     = '0;
    exp_lo     = '0;
    #1 RST = 1'b1;
    #1;
    check("rst_hi", {32'h0, HiOut}, 64'd0);
    check("rst_lo", {32'h0, LoOut}, 64'd0);
    check("rst_busy", {63'h0, Busy}, 64'd0);
    check("rst_dz", {63'h0, DivByZero}, 64'd0);
    ReadLoD = 1'b1;
    #1;
    check("rst_stall", {61'h0, StallF, StallD, FlushE}, 64'd0);
    ReadLoD = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Directed cases.
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'b01, 32'hFFFF_FFF9, 32'h0000_0003);
    do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op(2'b10, 32'h0000_0005, 32'h0000_0000);
    do_op(2'b01, 32'h0000_0006, 32'h0000_0007);
    do_op(2'b10, 32'd100, 32'd7);
    do_op(2'b10, 32'd1000, 32'd33);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b11, 32'hFFFF_FFF0, 32'h0000_0000);
    do_op(2'b11, 32'd7, 32'hFFFF_FFFE);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000);

    // Randomized ops, issued back to back.
    for (int i = 0; i < 50; i++) begin
      do_op(2'($urandom), pick_operand(), pick_operand());
    end

    // Ensure HI/LO are non-zero before the reset abort.
    do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);

    // Asynchronous reset mid-RUN at counter 10.
    StartE = 1'b1;
    OpE    = 2'b00;
    SrcAE  = 32'hDEAD_BEEF;
    SrcBE  = 32'h0000_1234;
    @(negedge CLK);
    StartE = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    ReadLoD = 1'b1;
    RST     = 1'b1;
    #1;
    check("abort_busy", {63'h0, Busy}, 64'd0);
    check("abort_hi", {32'h0, HiOut}, 64'd0);
    check("abort_lo", {32'h0, LoOut}, 64'd0);
    check("abort_stall", {61'h0, StallF, StallD, FlushE}, 64'd0);
    @(negedge CLK);
    RST     = 1'b0;
    ReadLoD = 1'b0;
    exp_hi  = '0;
    exp_lo  = '0;
    @(negedge CLK);
    do_op(2'b00, 32'd3, 32'd4);

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
